// File: rtl/wrp_bus_arbiter.sv
// wrp_bus_arbiter: shares the wrapper bus port between instruction fetch and load/store,
// one registered grant per transaction with a forced stb-low release cycle and a watchdog.
module wrp_bus_arbiter #(
    parameter int RR_MODE = 0,
    parameter int TIMEOUT = 1023
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ins_stb_i,
    input  logic [31:0] ins_adr_i,
    input  logic [3:0]  ins_burst_cnt_i,
    output logic [31:0] ins_dat_o,
    output logic        ins_ack_o,
    output logic        ins_done_o,
    input  logic        dat_stb_i,
    input  logic        dat_we_i,
    input  logic [31:0] dat_adr_i,
    input  logic [31:0] dat_dat_i,
    input  logic [3:0]  dat_sel_i,
    output logic [31:0] dat_dat_o,
    output logic        dat_ack_o,
    output logic        dat_done_o,
    output logic        err_o,
    output logic        wrp_stb_o,
    output logic        wrp_we_o,
    output logic [31:0] wrp_adr_o,
    output logic [31:0] wrp_dat_o,
    output logic [3:0]  wrp_sel_o,
    output logic [3:0]  wrp_burst_cnt_o,
    input  logic [31:0] wrp_dat_i,
    input  logic        wrp_ack_i,
    input  logic        wrp_ack_bus_i,
    output logic [1:0]  owner_o
);
    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, RELEASE} state_t;
    localparam logic [9:0] TLAST = 10'(TIMEOUT - 1);
    state_t      state_q, state_d;
    logic        last_owner_q, last_owner_d;
    logic [9:0]  wdog_q, wdog_d;
    logic        wrp_we_q, wrp_we_d;
    logic [31:0] wrp_adr_q, wrp_adr_d;
    logic [31:0] wrp_dat_q, wrp_dat_d;
    logic [3:0]  wrp_sel_q, wrp_sel_d;
    logic [3:0]  wrp_burst_q, wrp_burst_d;
    logic        gnt, tmo, fin, grant, pick_d;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            last_owner_q <= 1'b0;
            wdog_q       <= '0;
            wrp_we_q     <= 1'b0;
            wrp_adr_q    <= '0;
            wrp_dat_q    <= '0;
            wrp_sel_q    <= '0;
            wrp_burst_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            wdog_q       <= wdog_d;
            wrp_we_q     <= wrp_we_d;
            wrp_adr_q    <= wrp_adr_d;
            wrp_dat_q    <= wrp_dat_d;
            wrp_sel_q    <= wrp_sel_d;
            wrp_burst_q  <= wrp_burst_d;
        end
    end
    // last_owner_q: 0 = I served last, 1 = D served last
    always_comb begin
        gnt          = (state_q == GNT_I) || (state_q == GNT_D);
        tmo          = (TIMEOUT != 0) && (wdog_q == TLAST);
        fin          = gnt && (wrp_ack_bus_i || tmo);
        grant        = (state_q == IDLE) && (ins_stb_i || dat_stb_i);
        pick_d       = dat_stb_i && (!ins_stb_i || RR_MODE == 0 || !last_owner_q);
        state_d      = grant ? (pick_d ? GNT_D : GNT_I) :
                       fin ? RELEASE :
                       (state_q == RELEASE) ? IDLE : state_q;
        last_owner_d = fin ? (state_q == GNT_D) : last_owner_q;
        wdog_d       = gnt ? wdog_q + 10'd1 : '0;
        wrp_we_d     = grant ? (pick_d && dat_we_i) : wrp_we_q;
        wrp_adr_d    = grant ? (pick_d ? dat_adr_i : ins_adr_i) : wrp_adr_q;
        wrp_dat_d    = grant ? (pick_d ? dat_dat_i : 32'h0) : wrp_dat_q;
        wrp_sel_d    = grant ? (pick_d ? dat_sel_i : 4'hf) : wrp_sel_q;
        wrp_burst_d  = grant ? (pick_d ? 4'd1 : ins_burst_cnt_i) : wrp_burst_q;
    end
    always_comb begin
        wrp_stb_o       = gnt;
        wrp_we_o        = wrp_we_q;
        wrp_adr_o       = wrp_adr_q;
        wrp_dat_o       = wrp_dat_q;
        wrp_sel_o       = wrp_sel_q;
        wrp_burst_cnt_o = wrp_burst_q;
        owner_o         = {state_q == GNT_D, state_q == GNT_I};
        ins_ack_o       = (state_q == GNT_I) && wrp_ack_i;
        dat_ack_o       = (state_q == GNT_D) && wrp_ack_i;
        ins_dat_o       = ins_ack_o ? wrp_dat_i : 32'h0;
        dat_dat_o       = dat_ack_o ? wrp_dat_i : 32'h0;
        ins_done_o      = fin && (state_q == GNT_I);
        dat_done_o      = fin && (state_q == GNT_D);
        err_o           = gnt && tmo && !wrp_ack_bus_i;
    end
endmodule

// File: tb/tb_wrp_bus_arbiter.sv
// tb_wrp_bus_arbiter: fixed-priority and round-robin arbiters on shared stimulus,
// checked every cycle against a transaction-level model plus directed literal checks.
module tb_wrp_bus_arbiter;
    localparam int T = 8;
    logic        clk = 1'b0;
    logic        rst;
    logic        ins_stb, dat_stb, dat_we, wack, wack_bus;
    logic [31:0] ins_adr, dat_adr, dat_dat, wdat;
    logic [3:0]  ins_burst, dat_sel;
    logic [31:0] ins_dat_0, dat_dat_0, wrp_adr_0, wrp_dat_0, ins_dat_1, dat_dat_1, wrp_adr_1, wrp_dat_1;
    logic        ins_ack_0, ins_done_0, dat_ack_0, dat_done_0, err_0, wrp_stb_0, wrp_we_0;
    logic        ins_ack_1, ins_done_1, dat_ack_1, dat_done_1, err_1, wrp_stb_1, wrp_we_1;
    logic [3:0]  wrp_sel_0, wrp_burst_0, wrp_sel_1, wrp_burst_1;
    logic [1:0]  owner_0, owner_1;
    int total = 0;
    int bad = 0;
    always #5 clk = ~clk;

    wrp_bus_arbiter #(.RR_MODE(0), .TIMEOUT(T)) u0 (
        .clk_i(clk), .rst_i(rst),
        .ins_stb_i(ins_stb), .ins_adr_i(ins_adr), .ins_burst_cnt_i(ins_burst),
        .ins_dat_o(ins_dat_0), .ins_ack_o(ins_ack_0), .ins_done_o(ins_done_0),
        .dat_stb_i(dat_stb), .dat_we_i(dat_we), .dat_adr_i(dat_adr), .dat_dat_i(dat_dat),
        .dat_sel_i(dat_sel), .dat_dat_o(dat_dat_0), .dat_ack_o(dat_ack_0), .dat_done_o(dat_done_0),
        .err_o(err_0), .wrp_stb_o(wrp_stb_0), .wrp_we_o(wrp_we_0), .wrp_adr_o(wrp_adr_0),
        .wrp_dat_o(wrp_dat_0), .wrp_sel_o(wrp_sel_0), .wrp_burst_cnt_o(wrp_burst_0),
        .wrp_dat_i(wdat), .wrp_ack_i(wack), .wrp_ack_bus_i(wack_bus), .owner_o(owner_0));

    wrp_bus_arbiter #(.RR_MODE(1), .TIMEOUT(T)) u1 (
        .clk_i(clk), .rst_i(rst),
        .ins_stb_i(ins_stb), .ins_adr_i(ins_adr), .ins_burst_cnt_i(ins_burst),
        .ins_dat_o(ins_dat_1), .ins_ack_o(ins_ack_1), .ins_done_o(ins_done_1),
        .dat_stb_i(dat_stb), .dat_we_i(dat_we), .dat_adr_i(dat_adr), .dat_dat_i(dat_dat),
        .dat_sel_i(dat_sel), .dat_dat_o(dat_dat_1), .dat_ack_o(dat_ack_1), .dat_done_o(dat_done_1),
        .err_o(err_1), .wrp_stb_o(wrp_stb_1), .wrp_we_o(wrp_we_1), .wrp_adr_o(wrp_adr_1),
        .wrp_dat_o(wrp_dat_1), .wrp_sel_o(wrp_sel_1), .wrp_burst_cnt_o(wrp_burst_1),
        .wrp_dat_i(wdat), .wrp_ack_i(wack), .wrp_ack_bus_i(wack_bus), .owner_o(owner_1));

    logic [144:0] act0, act1;
    assign act0 = {wrp_stb_0, wrp_we_0, wrp_adr_0, wrp_dat_0, wrp_sel_0, wrp_burst_0,
                   ins_ack_0, ins_dat_0, ins_done_0, dat_ack_0, dat_dat_0, dat_done_0, err_0, owner_0};
    assign act1 = {wrp_stb_1, wrp_we_1, wrp_adr_1, wrp_dat_1, wrp_sel_1, wrp_burst_1,
                   ins_ack_1, ins_dat_1, ins_done_1, dat_ack_1, dat_dat_1, dat_done_1, err_1, owner_1};

    // own: 0 none, 1 I, 2 D; rel marks the forced low cycle after a transaction
    typedef struct {
        int          own;
        bit          rel;
        int          age;
        int          last;
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [3:0]  burst;
    } mdl_t;
    mdl_t m0, m1;

    function automatic logic [144:0] expv(mdl_t m);
        logic g, to, fin, ia, da;
        g   = m.own != 0;
        to  = g && m.age == T - 1;
        fin = g && (wack_bus || to);
        ia  = m.own == 1 && wack;
        da  = m.own == 2 && wack;
        return {g, m.we, m.adr, m.dat, m.sel, m.burst,
                ia, ia ? wdat : 32'h0, fin && m.own == 1,
                da, da ? wdat : 32'h0, fin && m.own == 2,
                to && !wack_bus, 2'(m.own)};
    endfunction

    function automatic mdl_t step(mdl_t m, bit rr);
        mdl_t n = m;
        int w;
        if (rst) begin
            n.own = 0; n.rel = 0; n.age = 0; n.last = 1;
            n.we = 0; n.adr = 0; n.dat = 0; n.sel = 0; n.burst = 0;
        end else if (m.own != 0) begin
            if (wack_bus || m.age == T - 1) begin
                n.last = m.own; n.own = 0; n.rel = 1;
            end else n.age = m.age + 1;
        end else if (m.rel) n.rel = 0;
        else if (ins_stb || dat_stb) begin
            if (ins_stb && dat_stb) w = rr ? (m.last == 1 ? 2 : 1) : 2;
            else w = dat_stb ? 2 : 1;
            n.own = w; n.age = 0;
            n.we    = w == 2 ? dat_we : 1'b0;
            n.adr   = w == 2 ? dat_adr : ins_adr;
            n.dat   = w == 2 ? dat_dat : 32'h0;
            n.sel   = w == 2 ? dat_sel : 4'hf;
            n.burst = w == 2 ? 4'd1 : ins_burst;
        end
        return n;
    endfunction

    task automatic chk(input string nm, input logic [144:0] a, input logic [144:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, a, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        bit armed = 0;
        forever begin
            @(negedge clk);
            if (armed) begin
                chk("rr0 outputs", act0, expv(m0));
                chk("rr1 outputs", act1, expv(m1));
            end
            m0 = step(m0, 1'b0);
            m1 = step(m1, 1'b1);
            if (rst) armed = 1;
        end
    end

    initial begin
        int g0[$];
        int g1[$];
        int exp_rr[4] = '{2, 1, 2, 1};
        rst = 1; ins_stb = 0; dat_stb = 0; dat_we = 0; wack = 0; wack_bus = 0;
        ins_adr = 0; dat_adr = 0; dat_dat = 0; wdat = 0; ins_burst = 0; dat_sel = 0;
        tick(); tick(); smp();
        chk("reset owner", owner_0, 2'b00);
        chk("reset stb", wrp_stb_1, 1'b0);
        chk("reset adr", wrp_adr_0, 32'h0);
        tick(); rst = 0;
        // instruction-only 4-beat burst
        ins_stb = 1; ins_adr = 32'h100; ins_burst = 4;
        tick();
        chk("model grant I", m0.own, 1);
        smp();
        chk("I owner", owner_0, 2'b01);
        chk("I stb", wrp_stb_0, 1'b1);
        chk("I burst", wrp_burst_0, 4'd4);
        chk("I sel", wrp_sel_0, 4'hf);
        chk("I adr", wrp_adr_0, 32'h100);
        for (int k = 0; k < 4; k++) begin
            tick(); wack = 1; wdat = 32'hA0 + k; wack_bus = (k == 3);
            smp();
            chk("I beat ack", ins_ack_0, 1'b1);
            chk("I beat dat", ins_dat_0, 32'hA0 + k);
            chk("I beat done", ins_done_0, k == 3);
            chk("I no D ack", dat_ack_0, 1'b0);
        end
        tick(); wack = 0; wack_bus = 0; ins_stb = 0;
        smp();
        chk("I release stb", wrp_stb_0, 1'b0);
        chk("I release owner", owner_0, 2'b00);
        tick();
        // simultaneous requests
        ins_stb = 1; ins_adr = 32'h300; ins_burst = 1;
        dat_stb = 1; dat_we = 0; dat_adr = 32'h200; dat_sel = 4'hf; dat_dat = 32'hDEADBEEF;
        tick();
        chk("model grant D", m0.own, 2);
        smp();
        chk("sim owner fp", owner_0, 2'b10);
        chk("sim owner rr", owner_1, 2'b10);
        chk("sim D adr", wrp_adr_0, 32'h200);
        tick(); wack = 1; wack_bus = 1; wdat = 32'h55;
        smp();
        chk("sim D ack", dat_ack_0, 1'b1);
        chk("sim D dat", dat_dat_0, 32'h55);
        chk("sim D done", dat_done_0, 1'b1);
        chk("sim I no ack", ins_ack_0, 1'b0);
        chk("sim I no dat", ins_dat_0, 32'h0);
        chk("sim I no done", ins_done_0, 1'b0);
        tick(); wack = 0; wack_bus = 0; dat_stb = 0;
        smp();
        chk("sim release stb", wrp_stb_0, 1'b0);
        tick(); smp();
        chk("sim idle stb", wrp_stb_0, 1'b0);
        tick(); smp();
        chk("sim then I fp", owner_0, 2'b01);
        chk("sim then I rr", owner_1, 2'b01);
        chk("sim I adr", wrp_adr_1, 32'h300);
        tick(); wack = 1; wack_bus = 1; wdat = 32'h66;
        smp();
        chk("sim I done", ins_done_0, 1'b1);
        chk("sim I dat", ins_dat_1, 32'h66);
        tick(); wack = 0; wack_bus = 0; ins_stb = 0;
        tick();
        // back-to-back contention
        ins_stb = 1; dat_stb = 1; wack = 1; wack_bus = 1; wdat = 32'h77;
        for (int c = 0; c < 40 && g1.size() < 4; c++) begin
            smp();
            if (owner_1 != 2'b00) begin
                g0.push_back(int'(owner_0));
                g1.push_back(int'(owner_1));
            end
        end
        chk("b2b grant count", g1.size(), 4);
        for (int i = 0; i < 4 && i < g1.size(); i++) begin
            chk("b2b rr order", g1[i], exp_rr[i]);
            chk("b2b fp order", g0[i], 2);
        end
        tick(); ins_stb = 0; dat_stb = 0; wack = 0; wack_bus = 0;
        tick();
        // unaligned D write split into sub-transactions
        dat_stb = 1; dat_we = 1; dat_adr = 32'h3FF; dat_sel = 4'hf; dat_dat = 32'h11223344;
        tick(); smp();
        chk("ua owner", owner_0, 2'b10);
        chk("ua we", wrp_we_0, 1'b1);
        chk("ua dat", wrp_dat_0, 32'h11223344);
        for (int k = 0; k < 3; k++) begin
            tick(); wack = 1; wdat = 0;
            smp();
            chk("ua stb held", wrp_stb_0, 1'b1);
            chk("ua adr held", wrp_adr_0, 32'h3FF);
            chk("ua no early done", dat_done_0, 1'b0);
        end
        tick(); wack_bus = 1;
        smp();
        chk("ua done", dat_done_0, 1'b1);
        chk("ua no err", err_0, 1'b0);
        tick(); wack = 0; wack_bus = 0; dat_stb = 0;
        tick();
        // watchdog abort
        dat_stb = 1; dat_we = 0; dat_adr = 32'h400; dat_sel = 4'h1;
        tick();
        chk("model wd age", m0.age, 0);
        for (int k = 0; k < T; k++) begin
            smp();
            chk("wd done", dat_done_0, k == T - 1);
            chk("wd err fp", err_0, k == T - 1);
            chk("wd err rr", err_1, k == T - 1);
            tick();
        end
        dat_stb = 0; wack = 1; wack_bus = 1;
        smp();
        chk("wd release stb", wrp_stb_0, 1'b0);
        chk("wd stray done", dat_done_0, 1'b0);
        chk("wd stray ack", dat_ack_0, 1'b0);
        tick(); smp();
        chk("wd idle stray done", dat_done_1, 1'b0);
        tick(); wack = 0; wack_bus = 0;
        // reset in the middle of an I burst
        ins_stb = 1; ins_adr = 32'h500; ins_burst = 4;
        tick(); tick(); wack = 1; wdat = 32'hB0;
        smp();
        chk("rst beat1 ack", ins_ack_0, 1'b1);
        tick(); wdat = 32'hB1; rst = 1;
        tick(); rst = 0; wack = 0;
        smp();
        chk("rst mid stb", wrp_stb_0, 1'b0);
        chk("rst mid owner", owner_1, 2'b00);
        chk("rst mid done", ins_done_0, 1'b0);
        chk("rst mid adr", wrp_adr_0, 32'h0);
        tick(); smp();
        chk("rst resume owner", owner_0, 2'b01);
        chk("rst resume adr", wrp_adr_1, 32'h500);
        tick(); wack = 1; wack_bus = 1; wdat = 32'hC0;
        smp();
        chk("rst resume done", ins_done_0, 1'b1);
        tick(); wack = 0; wack_bus = 0; ins_stb = 0;
        tick(); tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
